race_start_judge: RTL and testbench
===================================

Name: race_start_judge

Overview:
- Receiving end of the race-lights interface. It samples the R/Y/G outputs of the lights controller together with the driver's Go input.
- It checks that the light sequence is legal (Red, then Yellow, then Green).
- It flags a jump start if Go arrives before Green, and otherwise measures reaction time in clock cycles from Green.
- It sits beside the lights controller at the top level and feeds the scoreboard/display logic.

Parameters:
CNT_W, 8, width of the reaction-time counter and of ReactTime
TIMEOUT, 200, cycles in TIMING with Go low before giving up; must be < 2**CNT_W

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
R  input  1  red light from the lights controller
Y  input  1  yellow light from the lights controller
G  input  1  green light from the lights controller
Go  input  1  driver launch, level, synchronous to Clk
Armed  output  1  high in ARMED or STAGED
FalseStart  output  1  high in JUMP
Valid  output  1  high in DONE; ReactTime is meaningful
ReactTime  output  CNT_W  measured reaction cycles
TimedOut  output  1  high in TOUT
Fault  output  1  high in ERROR (illegal light pattern or order)
State  output  3  current state encoding, for debug

Behaviour:
- One clock, Clk. Reset is asynchronous and active-high.
- While Reset is high: state = IDLE, Cnt = 0, all outputs 0 (State = IDLE code).
- Moore machine. All outputs are registered and decoded from the state and the ReactTime register. No combinational path from inputs to outputs.
- Light pattern classes, sampled each rising edge:
  - OFF = 000, RED = 100, YEL = 010, GRN = 001 (bit order R,Y,G).
  - BAD = any pattern with more than one bit set.
- BAD in any state except ERROR → ERROR. BAD has highest priority.
- IDLE:
  - RED → ARMED. GRN or YEL → ERROR (out of order).
  - Go is ignored in IDLE.
- ARMED:
  - Go=1 → JUMP (takes priority over a light change on the same edge).
  - Otherwise: YEL → STAGED; GRN → ERROR; OFF → IDLE (race aborted); RED → stay.
- STAGED:
  - Go=1 → JUMP. This includes the edge on which GRN is first sampled, so Go coincident with Green is a jump start.
  - Otherwise: GRN → TIMING with Cnt <= 0; RED → ERROR; OFF → IDLE; YEL → stay.
- TIMING:
  - Go=1 → DONE, ReactTime <= Cnt (cycles spent in TIMING with Go low, 0 if Go is sampled on the first TIMING edge).
  - Go=0 and Cnt == TIMEOUT-1 → TOUT, ReactTime <= TIMEOUT.
  - Go=0 otherwise → Cnt <= Cnt+1.
  - Priority: a BAD pattern overrides everything; OFF → IDLE with no result; RED or YEL → ERROR.
- DONE, JUMP, TOUT, ERROR:
  - Held until lights are OFF on a sampled edge, then → IDLE.
  - Go is ignored. RED/YEL/GRN patterns do not change state.
- On every entry to IDLE, ReactTime and Cnt are cleared to 0.
- Cnt never wraps. TIMEOUT is reached before 2**CNT_W, so no arithmetic overflow.
- Reset asserted mid-race: immediate return to IDLE, all outputs 0.
  - After release, a controller still showing YEL or GRN drives → ERROR. Controller and judge are expected to share Reset.

Decomposition:
- Package race_lights_pkg holds:
  - light-pattern constants LIGHTS_OFF/RED/YEL/GRN (shared with the lights controller);
  - the state encoding IDLE=0, ARMED=1, STAGED=2, TIMING=3, DONE=4, JUMP=5, TOUT=6, ERROR=7;
  - the default CNT_W and TIMEOUT.
- One sub-module, reaction_counter: CNT_W-bit counter with synchronous clear, enable and terminal-count flag. It is instantiated once for Cnt.
- The FSM and output registers stay in race_start_judge.

Test Plan:
- Reset=1 for 2 edges, then lights RED(3 cycles) → YEL(3) → GRN, Go low for 5 sampled TIMING edges then high → Valid=1, ReactTime=5, Armed=0. Lights OFF → all outputs 0, State=IDLE.
- RED, then Go=1 while RED is steady → FalseStart=1 next edge. Holds through YEL/GRN; clears only after OFF.
- Go=1 on the same edge GRN is first sampled in STAGED → FalseStart=1, Valid=0.
- TIMEOUT=10, GRN with Go held low → after 10 TIMING edges TimedOut=1, ReactTime=10. A later Go has no effect.
- Pattern 110 during ARMED → Fault=1. RED→GRN skipping YEL → Fault=1. Each clears only after OFF.
- Reset pulse mid-TIMING (Cnt=4) → outputs 0 immediately, asynchronously, before the next edge. Full RED→YEL→GRN sequence afterwards measures normally from Cnt=0.

Source files
------------

// File: rtl/race_lights_pkg.sv
// rtl/race_lights_pkg.sv - shared light patterns, judge state encoding and defaults
package race_lights_pkg;

  // Light patterns, bit order {R,Y,G}; shared with the lights controller
  localparam logic [2:0] LIGHTS_OFF = 3'b000;
  localparam logic [2:0] LIGHTS_RED = 3'b100;
  localparam logic [2:0] LIGHTS_YEL = 3'b010;
  localparam logic [2:0] LIGHTS_GRN = 3'b001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    STAGED = 3'd2,
    TIMING = 3'd3,
    DONE   = 3'd4,
    JUMP   = 3'd5,
    TOUT   = 3'd6,
    ERROR  = 3'd7
  } judge_state_t;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 200;

  // More than one lamp lit at once is never a legal controller output
  function automatic logic is_bad(input logic [2:0] lights);
    return (lights & (lights - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/race_start_judge_if.sv
// rtl/race_start_judge_if.sv - lights/driver inputs and judge result outputs
interface race_start_judge_if
  import race_lights_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             R;
  logic             Y;
  logic             G;
  logic             Go;
  logic             Armed;
  logic             FalseStart;
  logic             Valid;
  logic [CNT_W-1:0] ReactTime;
  logic             TimedOut;
  logic             Fault;
  logic [2:0]       State;

  modport master (
    output R, Y, G, Go,
    input  Armed, FalseStart, Valid, ReactTime, TimedOut, Fault, State
  );

  modport slave (
    input  R, Y, G, Go,
    output Armed, FalseStart, Valid, ReactTime, TimedOut, Fault, State
  );
endinterface

// File: rtl/reaction_counter.sv
// rtl/reaction_counter.sv - reaction-time counter with clear, enable and terminal flag
module reaction_counter #(
  parameter int CNT_W = 8,
  parameter int TC    = 199
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(TC));

  // Count enabled cycles; clear wins, and the count stops at the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/race_start_judge.sv
// rtl/race_start_judge.sv - judges light sequence legality, jump starts and reaction time
module race_start_judge
  import race_lights_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               Clk,
  input logic               Reset,
  race_start_judge_if.slave bus
);

  logic [2:0]       lights;
  judge_state_t     state;
  judge_state_t     nxt;
  logic [CNT_W-1:0] react;
  logic [CNT_W-1:0] react_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_en;

  assign lights        = {bus.R, bus.Y, bus.G};
  assign bus.State     = state;
  assign bus.ReactTime = react;

  // Next state and result; a multi-lamp pattern overrides everything else
  always_comb begin
    nxt       = state;
    react_nxt = react;
    if (state != ERROR && is_bad(lights)) begin
      nxt = ERROR;
    end else begin
      case (state)
        IDLE: begin
          if (lights == LIGHTS_RED)      nxt = ARMED;
          else if (lights != LIGHTS_OFF) nxt = ERROR;
        end
        ARMED: begin
          if (bus.Go)                    nxt = JUMP;
          else if (lights == LIGHTS_YEL) nxt = STAGED;
          else if (lights == LIGHTS_GRN) nxt = ERROR;
          else if (lights == LIGHTS_OFF) nxt = IDLE;
        end
        STAGED: begin
          // Go sampled together with the first green still counts as a jump
          if (bus.Go)                    nxt = JUMP;
          else if (lights == LIGHTS_GRN) nxt = TIMING;
          else if (lights == LIGHTS_RED) nxt = ERROR;
          else if (lights == LIGHTS_OFF) nxt = IDLE;
        end
        TIMING: begin
          if (lights == LIGHTS_OFF) begin
            nxt = IDLE;
          end else if (lights != LIGHTS_GRN) begin
            nxt = ERROR;
          end else if (bus.Go) begin
            nxt       = DONE;
            react_nxt = cnt;
          end else if (tc) begin
            nxt       = TOUT;
            react_nxt = CNT_W'(TIMEOUT);
          end
        end
        default: begin
          if (lights == LIGHTS_OFF) nxt = IDLE;
        end
      endcase
    end
    if (nxt == IDLE) react_nxt = '0;
  end

  // Counter restarts on entry to TIMING or IDLE and runs while TIMING continues
  always_comb begin
    cnt_clr = (nxt == IDLE) || (state != TIMING && nxt == TIMING);
    cnt_en  = (state == TIMING) && (nxt == TIMING);
  end

  reaction_counter #(
    .CNT_W (CNT_W),
    .TC    (TIMEOUT - 1)
  ) u_cnt (
    .clk (Clk),
    .rst (Reset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (tc)
  );

  // State register with output flags decoded from the next state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      react          <= '0;
      bus.Armed      <= 1'b0;
      bus.FalseStart <= 1'b0;
      bus.Valid      <= 1'b0;
      bus.TimedOut   <= 1'b0;
      bus.Fault      <= 1'b0;
    end else begin
      state          <= nxt;
      react          <= react_nxt;
      bus.Armed      <= (nxt == ARMED) || (nxt == STAGED);
      bus.FalseStart <= (nxt == JUMP);
      bus.Valid      <= (nxt == DONE);
      bus.TimedOut   <= (nxt == TOUT);
      bus.Fault      <= (nxt == ERROR);
    end
  end

endmodule

// File: tb/tb_race_start_judge.sv
// tb/tb_race_start_judge.sv - scoreboard bench for race_start_judge
module tb_race_start_judge;
  import race_lights_pkg::*;

  localparam int TO = 10;
  localparam int S_IDLE = 0, S_ARMED = 1, S_STAGED = 2, S_TIMING = 3;
  localparam int S_DONE = 4, S_JUMP = 5, S_TOUT = 6, S_ERR = 7;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  race_start_judge_if #(.CNT_W(8)) bus ();

  race_start_judge #(.CNT_W(8), .TIMEOUT(TO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  // Reference: race phase plus the cycle stamp at which green was first seen
  int m_st = S_IDLE;
  int m_rt = 0;
  int m_green_t = 0;
  int now = 0;

  function automatic logic [15:0] dut_vec();
    return {bus.State, bus.Armed, bus.FalseStart, bus.Valid, bus.TimedOut,
            bus.Fault, bus.ReactTime};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [2:0] st;
    logic [7:0] rt;
    st = m_st[2:0];
    rt = m_rt[7:0];
    return {st, (m_st == S_ARMED || m_st == S_STAGED), m_st == S_JUMP,
            m_st == S_DONE, m_st == S_TOUT, m_st == S_ERR, rt};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic model(input logic [2:0] l, input bit go_v, input bit rs);
    int elapsed;
    now++;
    if (rs) begin
      m_st = S_IDLE;
      m_rt = 0;
      return;
    end
    elapsed = now - m_green_t - 1;
    if (m_st != S_ERR && $countones(l) > 1) begin
      m_st = S_ERR;
    end else if (m_st >= S_DONE) begin
      if (l == LIGHTS_OFF) m_st = S_IDLE;
    end else if (m_st == S_IDLE) begin
      if (l == LIGHTS_RED) m_st = S_ARMED;
      else if (l != LIGHTS_OFF) m_st = S_ERR;
    end else if (l == LIGHTS_OFF && !(go_v && m_st != S_TIMING)) begin
      m_st = S_IDLE;
    end else if (m_st == S_ARMED || m_st == S_STAGED) begin
      if (go_v) m_st = S_JUMP;
      else if (m_st == S_ARMED) begin
        if (l == LIGHTS_YEL) m_st = S_STAGED;
        else if (l == LIGHTS_GRN) m_st = S_ERR;
      end else begin
        if (l == LIGHTS_GRN) begin
          m_st = S_TIMING;
          m_green_t = now;
        end else if (l == LIGHTS_RED) m_st = S_ERR;
      end
    end else begin
      if (l != LIGHTS_GRN) m_st = S_ERR;
      else if (go_v) begin
        m_st = S_DONE;
        m_rt = elapsed;
      end else if (elapsed == TO - 1) begin
        m_st = S_TOUT;
        m_rt = TO;
      end
    end
    if (m_st == S_IDLE) m_rt = 0;
  endtask

  task automatic step(input logic [2:0] l, input bit go_v, input bit rs);
    @(negedge Clk);
    if (rs && !Reset) check("pre_rst_state", {13'd0, bus.State}, {13'd0, m_st[2:0]});
    Reset = rs;
    {bus.R, bus.Y, bus.G} = l;
    bus.Go = go_v;
    model(l, go_v, rs);
    exp_q.push_back(exp_vec());
    if (rs) begin
      #1;
      check("async_rst", dut_vec(), 16'd0);
    end
  endtask

  function automatic logic [2:0] pick(input logic [2:0] l);
    logic [2:0] bads[4];
    bads[0] = 3'b110; bads[1] = 3'b101; bads[2] = 3'b011; bads[3] = 3'b111;
    if ($urandom_range(0, 99) < 4) return bads[$urandom_range(0, 3)];
    return l;
  endfunction

  task automatic race();
    int rn, yn, k;
    rn = $urandom_range(1, 4);
    yn = $urandom_range(0, 4);
    k  = $urandom_range(0, 13);
    for (int i = 0; i < rn; i++) step(pick(LIGHTS_RED), $urandom_range(0, 99) < 6, 1'b0);
    for (int i = 0; i < yn; i++) step(pick(LIGHTS_YEL), $urandom_range(0, 99) < 6, 1'b0);
    for (int i = 0; i < k + 3; i++) step(pick(LIGHTS_GRN), i > k, 1'b0);
    for (int i = 0; i < 2; i++) step(LIGHTS_OFF, $urandom_range(0, 1) == 1, 1'b0);
  endtask

  task automatic normal(input int red_n, input int yel_n, input int low_n);
    for (int i = 0; i < red_n; i++) step(LIGHTS_RED, 1'b0, 1'b0);
    for (int i = 0; i < yel_n; i++) step(LIGHTS_YEL, 1'b0, 1'b0);
    for (int i = 0; i <= low_n; i++) step(LIGHTS_GRN, 1'b0, 1'b0);
    step(LIGHTS_GRN, 1'b1, 1'b0);
    step(LIGHTS_GRN, 1'b0, 1'b0);
    step(LIGHTS_OFF, 1'b0, 1'b0);
    step(LIGHTS_OFF, 1'b0, 1'b0);
  endtask

  // Monitor: one expected output vector per rising edge, compared after the edge
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", dut_vec(), e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    {bus.R, bus.Y, bus.G} = LIGHTS_OFF;
    bus.Go = 1'b0;
    step(LIGHTS_OFF, 1'b0, 1'b1);
    step(LIGHTS_OFF, 1'b0, 1'b1);
    normal(3, 3, 5);
    // Jump while red is steady, held through yellow/green
    step(LIGHTS_RED, 1'b0, 1'b0);
    step(LIGHTS_RED, 1'b1, 1'b0);
    step(LIGHTS_YEL, 1'b0, 1'b0);
    step(LIGHTS_GRN, 1'b1, 1'b0);
    step(LIGHTS_OFF, 1'b0, 1'b0);
    // Go coincident with first green
    step(LIGHTS_RED, 1'b0, 1'b0);
    step(LIGHTS_YEL, 1'b0, 1'b0);
    step(LIGHTS_GRN, 1'b1, 1'b0);
    step(LIGHTS_GRN, 1'b0, 1'b0);
    step(LIGHTS_OFF, 1'b0, 1'b0);
    // Timeout, later Go ignored
    step(LIGHTS_RED, 1'b0, 1'b0);
    step(LIGHTS_YEL, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(LIGHTS_GRN, 1'b0, 1'b0);
    step(LIGHTS_GRN, 1'b1, 1'b0);
    step(LIGHTS_OFF, 1'b0, 1'b0);
    // Faults: 110 while armed, red straight to green
    step(LIGHTS_RED, 1'b0, 1'b0);
    step(3'b110, 1'b0, 1'b0);
    step(LIGHTS_RED, 1'b0, 1'b0);
    step(LIGHTS_OFF, 1'b0, 1'b0);
    step(LIGHTS_RED, 1'b0, 1'b0);
    step(LIGHTS_GRN, 1'b0, 1'b0);
    step(LIGHTS_YEL, 1'b0, 1'b0);
    step(LIGHTS_OFF, 1'b0, 1'b0);
    // Reset mid-timing at count 4, then a clean race
    step(LIGHTS_RED, 1'b0, 1'b0);
    step(LIGHTS_YEL, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(LIGHTS_GRN, 1'b0, 1'b0);
    step(LIGHTS_GRN, 1'b0, 1'b1);
    step(LIGHTS_OFF, 1'b0, 1'b0);
    normal(3, 3, 3);
    for (int r = 0; r < 40; r++) race();
    for (int i = 0; i < 150; i++)
      step(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    repeat (3) @(negedge Clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
